// File: rtl/hazard_pkg.sv
// Shared hazard-unit constants: default geometry and the latency codes the
// decoder drives onto id_lat.
package hazard_pkg;

  localparam int ADDR_W_DEF  = 5;
  localparam int MAX_LAT_DEF = 4;

  // Cycles after issue before a result can be forwarded.
  localparam int LAT_ALU  = 0;
  localparam int LAT_LOAD = 1;
  localparam int LAT_MUL  = 3;

  // Limit a requested latency to the largest one the scoreboard tracks.
  function automatic int unsigned clamp_lat(input int unsigned lat,
                                            input int unsigned max_lat);
    return (lat > max_lat) ? max_lat : lat;
  endfunction

endpackage

// File: rtl/hazard_sb_entry.sv
// One scoreboard entry: cycles remaining until a register's pending result
// becomes forwardable. Counts down to zero, or takes the larger of the new
// and remaining latency when a producer issues to it.
module hazard_sb_entry #(
  parameter int LAT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [LAT_W-1:0] lat,
  output logic [LAT_W-1:0] cnt
);

  logic [LAT_W-1:0] dec;

  // Next value when no producer issues: one cycle closer, stopping at zero.
  always_comb begin
    dec = (cnt != '0) ? cnt - LAT_W'(1) : '0;
  end

  // Keep the larger latency so an older, slower producer is never hidden.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every entry
    // updates from the same pre-edge values.
    if (!rst_n)
      cnt <= '0;
    else if (load && (lat > dec))
      cnt <= lat;
    else
      cnt <= dec;
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Load/multi-cycle hazard unit beside the ID stage. Per-register countdown
// entries record results that cannot yet be forwarded; a dependent
// instruction in ID is held until its sources are forwardable. Flush beats
// a hazard, and a saturating counter tracks stalled cycles.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int MAX_LAT = MAX_LAT_DEF,
  parameter int LAT_W   = $clog2(MAX_LAT + 1),
  parameter int PERF_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [ADDR_W-1:0] id_rs,
  input  logic [ADDR_W-1:0] id_rt,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic [ADDR_W-1:0] id_rd,
  input  logic              id_wr,
  input  logic [LAT_W-1:0]  id_lat,
  input  logic              flush,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              stall,
  output logic              hazard_rs,
  output logic              hazard_rt,
  output logic [PERF_W-1:0] stall_count
);

  localparam int NREG = 2 ** ADDR_W;

  logic [LAT_W-1:0] cnt [NREG];
  logic [LAT_W-1:0] lat_eff;
  logic             hz;
  logic             issue;

  // Register 0 is hard-wired forwardable; every other register gets an entry.
  for (genvar r = 0; r < NREG; r++) begin : g_entry
    if (r == 0) begin : g_zero
      assign cnt[r] = '0;
    end else begin : g_cnt
      hazard_sb_entry #(
        .LAT_W (LAT_W)
      ) u_entry (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (issue && id_wr && (id_rd == ADDR_W'(r))),
        .lat   (lat_eff),
        .cnt   (cnt[r])
      );
    end
  end

  // Hazard and stall decode straight from the registered scoreboard; while in
  // reset the pipeline is forced to run free.
  always_comb begin
    // NOTE: every output of this block is assigned on every path, so no
    // latch can be inferred.
    hazard_rs  = rst_n && id_valid && id_rs_used && (id_rs != '0) &&
                 (cnt[id_rs] != '0);
    hazard_rt  = rst_n && id_valid && id_rt_used && (id_rt != '0) &&
                 (cnt[id_rt] != '0);
    hz         = hazard_rs || hazard_rt;
    stall      = hz && !flush;
    pc_write   = !stall;
    ifid_write = !stall;
    issue      = id_valid && !stall && !flush;
    lat_eff    = LAT_W'(clamp_lat(32'(id_lat), MAX_LAT));
  end

  // Count stalled cycles, holding at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n)
      stall_count <= '0;
    else if (stall && (stall_count != '1))
      stall_count <= stall_count + PERF_W'(1);
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard. A reference model keeps, per
// register, the absolute cycle at which its result becomes forwardable and
// checks every output on every cycle; directed sequences pin the model with
// hand-computed stall counts.
module tb_hazard_scoreboard;

  localparam int  PERF_MAX   = 65535;
  localparam int  MAXL       = 4;
  localparam int  SAT_TARGET = 65536 + 5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_rs_used;
  logic       id_rt_used;
  logic [4:0] id_rd;
  logic       id_wr;
  logic [2:0] id_lat;
  logic       flush;
  logic       pc_write;
  logic       ifid_write;
  logic       stall;
  logic       hazard_rs;
  logic       hazard_rt;
  logic [15:0] stall_count;

  int n_checks = 0;
  int n_pass   = 0;

  hazard_scoreboard dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_rs_used  (id_rs_used),
    .id_rt_used  (id_rt_used),
    .id_rd       (id_rd),
    .id_wr       (id_wr),
    .id_lat      (id_lat),
    .flush       (flush),
    .pc_write    (pc_write),
    .ifid_write  (ifid_write),
    .stall       (stall),
    .hazard_rs   (hazard_rs),
    .hazard_rt   (hazard_rt),
    .stall_count (stall_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  longint cyc = 0;
  longint ready [32];
  longint model_total = 0;
  logic   e_rs, e_rt, e_st;
  longint e_cnt;
  longint l_eff;

  always @(negedge clk) begin
    e_rs  = rst_n && id_valid && id_rs_used && (id_rs != 0) && (ready[id_rs] > cyc);
    e_rt  = rst_n && id_valid && id_rt_used && (id_rt != 0) && (ready[id_rt] > cyc);
    e_st  = (e_rs || e_rt) && !flush;
    e_cnt = (model_total > PERF_MAX) ? PERF_MAX : model_total;
    check("hazard_rs",   hazard_rs,   e_rs);
    check("hazard_rt",   hazard_rt,   e_rt);
    check("stall",       stall,       e_st);
    check("pc_write",    pc_write,    !e_st);
    check("ifid_write",  ifid_write,  !e_st);
    check("stall_count", stall_count, e_cnt);
    if (!rst_n) begin
      foreach (ready[i]) ready[i] = 0;
      model_total = 0;
    end else begin
      if (e_st) model_total++;
      if (id_valid && !e_st && !flush && id_wr && (id_rd != 0)) begin
        l_eff = (id_lat > MAXL) ? MAXL : longint'(id_lat);
        if (cyc + 1 + l_eff > ready[id_rd]) ready[id_rd] = cyc + 1 + l_eff;
      end
    end
    cyc++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic put(input logic v, input logic [4:0] rs, input logic rsu,
                     input logic [4:0] rt, input logic rtu, input logic [4:0] rd,
                     input logic wr, input logic [2:0] lat, input logic fl);
    @(posedge clk); #1;
    id_valid = v; id_rs = rs; id_rs_used = rsu; id_rt = rt; id_rt_used = rtu;
    id_rd = rd; id_wr = wr; id_lat = lat; flush = fl;
  endtask

  task automatic nop();
    put(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic reset_dut();
    @(posedge clk); #1;
    rst_n = 0;
    id_valid = 0; id_rs = 0; id_rs_used = 0; id_rt = 0; id_rt_used = 0;
    id_rd = 0; id_wr = 0; id_lat = 0; flush = 0;
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  // Count consecutive stalled cycles of the instruction now in ID.
  task automatic count_stalls(output int n);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!stall) break;
      n++;
    end
  endtask

  int n_st;
  int guard;

  initial begin
    rst_n = 0;
    id_valid = 0; id_rs = 0; id_rs_used = 0; id_rt = 0; id_rt_used = 0;
    id_rd = 0; id_wr = 0; id_lat = 0; flush = 0;

    // Reset state
    reset_dut();
    @(negedge clk);
    check("rst_stall_count", stall_count, 0);
    check("rst_pc_write", pc_write, 1);

    // Load-use: lw $8 then add $9,$8,$1
    put(1, 0, 0, 0, 0, 8, 1, 1, 0);
    put(1, 8, 1, 1, 1, 9, 1, 0, 0);
    @(negedge clk);
    check("lu_stall", stall, 1);
    check("lu_pc_write", pc_write, 0);
    check("lu_ifid_write", ifid_write, 0);
    check("lu_hazard_rs", hazard_rs, 1);
    @(negedge clk);
    check("lu_released", stall, 0);
    check("lu_stall_count", stall_count, 1);
    nop();

    // mul $10 (lat 3) then consumer
    reset_dut();
    put(1, 0, 0, 0, 0, 10, 1, 3, 0);
    put(1, 10, 1, 0, 0, 11, 1, 0, 0);
    count_stalls(n_st);
    check("mul_stalls", n_st, 3);
    nop();
    @(negedge clk);
    check("mul_stall_count", stall_count, 3);

    // mul $10, two independent instructions, consumer
    reset_dut();
    put(1, 0, 0, 0, 0, 10, 1, 3, 0);
    put(1, 1, 1, 2, 1, 12, 1, 0, 0);
    put(1, 3, 1, 4, 1, 13, 1, 0, 0);
    put(1, 1, 1, 10, 1, 11, 1, 0, 0);
    count_stalls(n_st);
    check("mul_gap_stalls", n_st, 1);
    nop();

    // Load to $0 then reader of $0
    reset_dut();
    put(1, 0, 0, 0, 0, 0, 1, 1, 0);
    put(1, 0, 1, 0, 1, 9, 1, 0, 0);
    @(negedge clk);
    check("r0_stall", stall, 0);

    // Unused rt pointing at pending register
    reset_dut();
    put(1, 0, 0, 0, 0, 7, 1, 1, 0);
    put(1, 1, 1, 7, 0, 9, 1, 0, 0);
    @(negedge clk);
    check("unused_rt_stall", stall, 0);
    check("unused_rt_hazard", hazard_rt, 0);
    nop();

    // WAW: mul $5 then lw $5 then consumer of $5
    reset_dut();
    put(1, 0, 0, 0, 0, 5, 1, 3, 0);
    put(1, 0, 0, 0, 0, 5, 1, 1, 0);
    put(1, 5, 1, 0, 0, 6, 1, 0, 0);
    count_stalls(n_st);
    check("waw_stalls", n_st, 2);
    nop();

    // Latency above the maximum is clamped
    reset_dut();
    put(1, 0, 0, 0, 0, 3, 1, 7, 0);
    put(1, 0, 0, 3, 1, 4, 1, 0, 0);
    count_stalls(n_st);
    check("clamp_stalls", n_st, 4);
    nop();

    // Flush over hazard; the flushed write must not reach the scoreboard
    reset_dut();
    put(1, 0, 0, 0, 0, 8, 1, 1, 0);
    put(1, 8, 1, 0, 0, 12, 1, 4, 1);
    @(negedge clk);
    check("flush_stall", stall, 0);
    check("flush_pc_write", pc_write, 1);
    check("flush_hazard_rs", hazard_rs, 1);
    put(1, 12, 1, 0, 0, 13, 1, 0, 0);
    @(negedge clk);
    check("flush_no_write", stall, 0);
    check("flush_stall_count", stall_count, 0);
    nop();

    // Reset in the middle of a stall
    reset_dut();
    put(1, 0, 0, 0, 0, 10, 1, 3, 0);
    put(1, 10, 1, 0, 0, 11, 1, 0, 0);
    @(negedge clk);
    check("mid_stall_before", stall, 1);
    @(posedge clk); #1;
    rst_n = 0;
    @(negedge clk);
    check("mid_rst_stall", stall, 0);
    check("mid_rst_pc_write", pc_write, 1);
    check("mid_rst_hazard", hazard_rs, 0);
    @(posedge clk); #1;
    rst_n = 1;
    @(negedge clk);
    check("mid_after_stall", stall, 0);
    check("mid_after_count", stall_count, 0);
    nop();

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      rst_n      = ($urandom_range(0, 49) != 0);
      id_valid   = ($urandom_range(0, 9) != 0);
      id_rs      = 5'($urandom_range(0, 7));
      id_rt      = 5'($urandom_range(0, 7));
      id_rs_used = 1'($urandom_range(0, 1));
      id_rt_used = 1'($urandom_range(0, 1));
      id_rd      = 5'($urandom_range(0, 7));
      id_wr      = 1'($urandom_range(0, 1));
      id_lat     = 3'($urandom_range(0, 7));
      flush      = ($urandom_range(0, 9) == 0);
    end
    @(posedge clk); #1;
    rst_n = 1;

    // Saturation: self-dependent lat-4 producer stalls 4 of every 5 cycles
    reset_dut();
    put(1, 20, 1, 0, 0, 20, 1, 4, 0);
    guard = 0;
    while (model_total < SAT_TARGET && guard < 90000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 90000) check("sat_budget", guard, 0);
    nop();
    @(negedge clk);
    @(negedge clk);
    check("stall_count_sat", stall_count, 16'hFFFF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
